// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_write_arbiter_pkg : shared widths, constants and grant encoding    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rf_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MDU  = 2'd2
  } gnt_e;

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_write_arbiter_if : requester/decode/register-file bundle          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rf_write_arbiter_if;
  import rf_write_arbiter_pkg::*;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  mdu_valid;
  logic                  mdu_ready;
  logic [REG_ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0]     mdu_data;
  logic                  iss_valid;
  logic                  iss_ready;
  logic [REG_ADDR_W-1:0] iss_addr;
  logic [REG_ADDR_W-1:0] rd_addr1;
  logic [REG_ADDR_W-1:0] rd_addr2;
  logic                  busy1;
  logic                  busy2;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  sb_err;

  modport master (
    output wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
           iss_valid, iss_addr, rd_addr1, rd_addr2,
    input  wb_ready, mdu_ready, iss_ready, busy1, busy2,
           rf_we, rf_addr, rf_wdata, sb_err
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
           iss_valid, iss_addr, rd_addr1, rd_addr2,
    output wb_ready, mdu_ready, iss_ready, busy1, busy2,
           rf_we, rf_addr, rf_wdata, sb_err
  );

endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_scoreboard : pending-MDU-destination bitmap and hazard query      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rf_scoreboard
  import rf_write_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  output logic                  iss_ready,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  sb_err
);

  localparam logic [5:0] c_max_out = 6'(MAX_OUTSTANDING);

  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;
  logic [5:0]  r_count;
  logic        r_sb_err;
  logic        w_iss_fire;
  logic        w_clr_hit;
  logic        w_clr_miss;

  // Readiness looks at the old pending bit, so a same-cycle re-issue of a
  // register being retired is refused.
  assign iss_ready  = (iss_addr == REG_ZERO) ||
                      (!r_pending[iss_addr] && (r_count < c_max_out));
  assign w_iss_fire = iss_valid && iss_ready && (iss_addr != REG_ZERO);
  assign w_clr_hit  = clr_valid && (clr_addr != REG_ZERO) && r_pending[clr_addr];
  assign w_clr_miss = clr_valid && (clr_addr != REG_ZERO) && !r_pending[clr_addr];

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_clr_hit)  w_pending_nxt[clr_addr] = 1'b0;
    if (w_iss_fire) w_pending_nxt[iss_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_count   <= '0;
      r_sb_err  <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_count   <= r_count + 6'(w_iss_fire) - 6'(w_clr_hit);
      if (w_clr_miss) r_sb_err <= 1'b1;
    end
  end

  assign busy1  = (rd_addr1 != REG_ZERO) && r_pending[rd_addr1];
  assign busy2  = (rd_addr2 != REG_ZERO) && r_pending[rd_addr2];
  assign sb_err = r_sb_err;

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_write_arbiter : WB/MDU arbitration onto the single RF write port  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rf_write_arbiter_if.slave   bus
);

  localparam int c_sw = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_sw-1:0] c_starve_lim = c_sw'(STARVE_LIMIT);

  logic [c_sw-1:0]       r_starve;
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0]     r_rf_wdata;
  logic                  w_mdu_win;
  gnt_e                  w_gnt;

  // WB normally wins; the MDU is forced through once it has been refused
  // STARVE_LIMIT cycles in a row.
  assign w_mdu_win     = bus.mdu_valid && (!bus.wb_valid || (r_starve == c_starve_lim));
  assign bus.mdu_ready = w_mdu_win;
  assign bus.wb_ready  = !(w_mdu_win && bus.wb_valid);

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_mdu_win)         w_gnt = GNT_MDU;
    else if (bus.wb_valid) w_gnt = GNT_WB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve   <= '0;
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
    end else begin
      if (!bus.mdu_valid || w_mdu_win) r_starve <= '0;
      else if (r_starve != c_starve_lim) r_starve <= r_starve + 1'b1;

      case (w_gnt)
        GNT_MDU: begin
          r_rf_we    <= (bus.mdu_addr != REG_ZERO);
          r_rf_addr  <= bus.mdu_addr;
          r_rf_wdata <= bus.mdu_data;
        end
        GNT_WB: begin
          r_rf_we    <= (bus.wb_addr != REG_ZERO);
          r_rf_addr  <= bus.wb_addr;
          r_rf_wdata <= bus.wb_data;
        end
        default: r_rf_we <= 1'b0;
      endcase
    end
  end

  assign bus.rf_we    = r_rf_we;
  assign bus.rf_addr  = r_rf_addr;
  assign bus.rf_wdata = r_rf_wdata;

  rf_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (bus.iss_valid),
    .iss_addr  (bus.iss_addr),
    .iss_ready (bus.iss_ready),
    .clr_valid (w_mdu_win),
    .clr_addr  (bus.mdu_addr),
    .rd_addr1  (bus.rd_addr1),
    .rd_addr2  (bus.rd_addr2),
    .busy1     (bus.busy1),
    .busy2     (bus.busy2),
    .sb_err    (bus.sb_err)
  );

endmodule
`default_nettype wire
